// File: rtl/fifo_sync_ext.sv
// +------------------------------------------------------------------------+
// | fifo_sync_ext : single-clock FIFO with level flags, sticky errors, FWFT |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module fifo_sync_ext #(
  parameter int DW       = 4,
  parameter int AW       = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          winc,
  input  logic [DW-1:0] wdata,
  input  logic          rinc,
  input  logic          clr_err,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          c_depth     = 1 << AW;
  localparam logic [AW:0] c_depth_cnt = (AW+1)'(c_depth);
  localparam logic [AW:0] c_af_level  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] c_ae_level  = (AW+1)'(AE_LEVEL);

  logic [DW-1:0] mem_q [c_depth];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          w_wr_ok;
  logic          w_rd_ok;

  // Acceptance is judged on the registered flags, so no request input reaches an output.
  assign full         = (count_q == c_depth_cnt);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= c_af_level);
  assign almost_empty = (count_q <= c_ae_level);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign w_wr_ok = winc & ~full;
  assign w_rd_ok = rinc & ~empty;

  always_comb begin
    wptr_d  = w_wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = w_rd_ok ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A rejection in the same cycle as clr_err keeps the flag set.
    ovf_d = (winc & full)  | (ovf_q & ~clr_err);
    unf_d = (rinc & empty) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty ? '0 : mem_q[rptr_q];
    end else begin : g_reg_read
      logic [DW-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (w_rd_ok) begin
          rdata_q <= mem_q[rptr_q];
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_ext.sv
// +------------------------------------------------------------------------+
// | tb_fifo_sync_ext : directed self-checking bench for fifo_sync_ext       |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_sync_ext;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a_: default registered-read FIFO, b_: FWFT, c_: AF=8/AE=0 thresholds
  logic       a_winc = 0, a_rinc = 0, a_clr = 0;
  logic [3:0] a_wdata = 0, a_rdata;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_count;

  logic       b_winc = 0, b_rinc = 0, b_clr = 0;
  logic [3:0] b_wdata = 0, b_rdata;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0] b_count;

  logic       c_winc = 0, c_rinc = 0, c_clr = 0;
  logic [3:0] c_wdata = 0, c_rdata;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [3:0] c_count;

  int n_total = 0;
  int n_bad   = 0;

  fifo_sync_ext #(.DW(4), .AW(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .winc(a_winc), .wdata(a_wdata), .rinc(a_rinc),
    .clr_err(a_clr), .rdata(a_rdata), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_sync_ext #(.DW(4), .AW(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .winc(b_winc), .wdata(b_wdata), .rinc(b_rinc),
    .clr_err(b_clr), .rdata(b_rdata), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  fifo_sync_ext #(.DW(4), .AW(3), .AF_LEVEL(8), .AE_LEVEL(0), .FWFT(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .winc(c_winc), .wdata(c_wdata), .rinc(c_rinc),
    .clr_err(c_clr), .rdata(c_rdata), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [3:0] d);
    a_winc = 1; a_wdata = d; tick(); a_winc = 0;
  endtask

  task automatic a_read();
    a_rinc = 1; tick(); a_rinc = 0;
  endtask

  task automatic a_clear();
    a_clr = 1; tick(); a_clr = 0;
  endtask

  function automatic logic [3:0] seq(input int k);
    return 4'((k * 3 + 1) & 15);
  endfunction

  initial begin
    #12 rst_n = 1'b1;
    tick();

    // reset state
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_ae",    a_ae, 1);
    check("rst_full",  a_full, 0);
    check("rst_af",    a_af, 0);
    check("rst_ovf",   a_ovf, 0);
    check("rst_unf",   a_unf, 0);
    check("rst_rdata", a_rdata, 0);

    // fill 1..8, then a rejected ninth write
    for (int i = 1; i <= 8; i++) begin
      a_write(4'(i));
      check("fill_count", a_count, i);
      check("fill_af",    a_af, (i >= 6));
      check("fill_ae",    a_ae, (i <= 2));
      check("fill_full",  a_full, (i == 8));
    end
    a_write(4'hF);
    check("ovf_set",   a_ovf, 1);
    check("ovf_count", a_count, 8);

    for (int i = 1; i <= 8; i++) begin
      a_read();
      check("drain_data",  a_rdata, i);
      check("drain_count", a_count, 8 - i);
    end
    check("drain_empty", a_empty, 1);
    a_clear();
    check("ovf_clr", a_ovf, 0);

    // underflow and clear priority
    a_read();
    check("unf_set",   a_unf, 1);
    check("unf_rdata", a_rdata, 8);
    check("unf_count", a_count, 0);
    a_clear();
    check("unf_clr", a_unf, 0);
    a_clr = 1; a_rinc = 1; tick(); a_clr = 0; a_rinc = 0;
    check("unf_clr_vs_set", a_unf, 1);
    a_clear();

    // simultaneous at count 3 with wrap-around
    for (int k = 0; k < 3; k++) a_write(seq(k));
    check("sim_pre_count", a_count, 3);
    for (int j = 0; j < 20; j++) begin
      a_winc = 1; a_rinc = 1; a_wdata = seq(3 + j);
      tick();
      check("sim_count", a_count, 3);
      check("sim_data",  a_rdata, seq(j));
    end
    a_winc = 0; a_rinc = 0;
    for (int j = 20; j < 23; j++) begin
      a_read();
      check("sim_tail", a_rdata, seq(j));
    end
    check("sim_ovf", a_ovf, 0);
    check("sim_unf", a_unf, 0);

    // simultaneous at full
    for (int i = 0; i < 8; i++) a_write(4'(i));
    a_winc = 1; a_rinc = 1; a_wdata = 4'hE; tick(); a_winc = 0; a_rinc = 0;
    check("simfull_count", a_count, 7);
    check("simfull_ovf",   a_ovf, 1);
    check("simfull_rdata", a_rdata, 0);
    for (int i = 1; i < 8; i++) begin
      a_read();
      check("simfull_drain", a_rdata, i);
    end
    a_clear();

    // simultaneous at empty
    a_winc = 1; a_rinc = 1; a_wdata = 4'h5; tick(); a_winc = 0; a_rinc = 0;
    check("simempty_count", a_count, 1);
    check("simempty_unf",   a_unf, 1);
    a_read();
    check("simempty_data", a_rdata, 5);
    check("simempty_cnt0", a_count, 0);
    a_clear();

    // FWFT mode
    check("fw_rst_rdata", b_rdata, 0);
    b_winc = 1; b_wdata = 4'hA; tick(); b_winc = 0;
    check("fw_rdata", b_rdata, 4'hA);
    check("fw_empty", b_empty, 0);
    tick();
    check("fw_hold", b_rdata, 4'hA);
    b_winc = 1; b_wdata = 4'hB; tick(); b_winc = 0;
    check("fw_head", b_rdata, 4'hA);
    b_rinc = 1; tick(); b_rinc = 0;
    check("fw_next", b_rdata, 4'hB);
    b_rinc = 1; tick(); b_rinc = 0;
    check("fw_rd_rdata", b_rdata, 0);
    check("fw_rd_empty", b_empty, 1);

    // threshold sweep at AF=8, AE=0
    for (int i = 0; i <= 8; i++) begin
      check("thr_up_af", c_af, (i == 8));
      check("thr_up_ae", c_ae, (i == 0));
      check("thr_up_full", c_full, (i == 8));
      check("thr_up_empty", c_empty, (i == 0));
      if (i < 8) begin
        c_winc = 1; c_wdata = 4'(i); tick(); c_winc = 0;
      end
    end
    for (int i = 7; i >= 0; i--) begin
      c_rinc = 1; tick(); c_rinc = 0;
      check("thr_dn_af", c_af, (i == 8));
      check("thr_dn_ae", c_ae, (i == 0));
    end

    // reset mid-operation: count 5 with overflow set
    for (int i = 0; i < 8; i++) a_write(4'(i + 1));
    a_write(4'h9);
    for (int i = 0; i < 3; i++) a_read();
    check("mid_pre_count", a_count, 5);
    check("mid_pre_ovf",   a_ovf, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_count", a_count, 0);
    check("mid_empty", a_empty, 1);
    check("mid_ae",    a_ae, 1);
    check("mid_full",  a_full, 0);
    check("mid_af",    a_af, 0);
    check("mid_ovf",   a_ovf, 0);
    check("mid_unf",   a_unf, 0);
    check("mid_rdata", a_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_write(4'h3);
    check("post_count", a_count, 1);
    a_read();
    check("post_rdata", a_rdata, 3);
    check("post_empty", a_empty, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
